unified_mem_arbiter: RTL

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Ports: if_* fetch side, d_* data side, mem_* memory side, flush, busy.
module unified_mem_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [2:0] LP_SMAX = 3'(STARVE_MAX);
  localparam logic [2:0] LP_CNT  = 3'(LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_starve;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_we;
  logic        r_is_f;
  logic        r_kill;
  logic        r_if_gnt;
  logic        r_d_gnt;
  logic        r_d_done;

  logic w_idle;
  logic w_acc;
  logic w_done;
  logic w_f_win;
  logic w_d_win;
  logic w_acc_end;
  logic w_if_live;

  assign w_idle    = (r_state == IDLE);
  assign w_acc     = (r_state == ACCESS);
  assign w_done    = (r_state == DONE);
  assign w_f_win   = if_req &&
                     (!d_req || (r_starve == LP_SMAX));
  assign w_d_win   = d_req && !w_f_win;
  assign w_acc_end = w_acc && (r_cnt == 3'd0);
  // Fetch return is visible only when no flush
  // was seen during the access and none is seen now.
  assign w_if_live = w_done && r_is_f &&
                     !r_kill && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (if_req || d_req) w_next = ACCESS;
      ACCESS:  if (r_cnt == 3'd0)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve   <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_we       <= 1'b0;
      r_is_f     <= 1'b0;
      r_kill     <= 1'b0;
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_d_done   <= 1'b0;
    end else begin
      r_if_gnt <= w_idle && w_f_win;
      r_d_gnt  <= w_idle && w_d_win;
      r_d_done <= w_acc_end && !r_is_f;
      if (w_idle) begin
        if (w_f_win || !if_req)
          r_starve <= '0;
        else if (r_starve < LP_SMAX)
          r_starve <= r_starve + 3'd1;
        if (w_f_win || w_d_win) begin
          r_addr  <= w_f_win ? if_addr : d_addr;
          r_wdata <= w_f_win ? '0 : d_wdata;
          r_we    <= w_d_win && d_we;
          r_is_f  <= w_f_win;
          r_kill  <= 1'b0;
          r_cnt   <= LP_CNT;
        end
      end
      if (w_acc && (r_cnt != 3'd0))
        r_cnt <= r_cnt - 3'd1;
      if (w_acc_end) begin
        if (r_is_f)
          r_rbuf <= mem_rdata;
        else if (!r_we)
          r_d_rdata <= mem_rdata;
      end
      if (r_is_f && flush && (w_acc || w_done))
        r_kill <= 1'b1;
      if (w_if_live)
        r_if_rdata <= r_rbuf;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = w_if_live;
  assign if_rdata  = w_if_live ? r_rbuf : r_if_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = w_acc && r_we;
  assign busy      = !w_idle;

endmodule
